// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day counter: digit widths and the
// terminal value of each field, kept as BCD tens/units pairs.
package clock_pkg;

    // Digit widths
    localparam int UNITS_W     = 4;
    localparam int SEC_TENS_W  = 3;
    localparam int MIN_TENS_W  = 3;
    localparam int HOUR_TENS_W = 2;

    // Largest units digit in any field
    localparam int UNITS_MAX = 9;

    // SEC_MAX = 59
    localparam int SEC_TENS_MAX  = 5;
    localparam int SEC_UNITS_MAX = 9;

    // MIN_MAX = 59
    localparam int MIN_TENS_MAX  = 5;
    localparam int MIN_UNITS_MAX = 9;

    // HOUR_MAX = 23
    localparam int HOUR_TENS_MAX  = 2;
    localparam int HOUR_UNITS_MAX = 3;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after reaching TENS_MAX /
// UNITS_MAX_AT_TENS_MAX. A synchronous clear takes priority over a step.
// at_max is decoded from the registered digits, so it is stable all cycle
// and the parent can build its carry chain from it within the same edge.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int TENS_W                = 3,
    parameter int TENS_MAX              = 5,
    parameter int UNITS_MAX_AT_TENS_MAX = 9
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_Clear,
    input  logic               i_Step,
    output logic [UNITS_W-1:0] o_Units,
    output logic [TENS_W-1:0]  o_Tens,
    output logic               o_At_Max
);

    localparam logic [TENS_W-1:0]  TENS_LAST  = TENS_W'(TENS_MAX);
    localparam logic [UNITS_W-1:0] UNITS_LAST = UNITS_W'(UNITS_MAX_AT_TENS_MAX);
    localparam logic [UNITS_W-1:0] UNITS_NINE = UNITS_W'(UNITS_MAX);

    logic [UNITS_W-1:0] units_q;
    logic [TENS_W-1:0]  tens_q;

    // Terminal-count decode used for both wrap and the outgoing carry
    always_comb begin
        o_At_Max = (tens_q == TENS_LAST) && (units_q == UNITS_LAST);
    end

    // Digit registers: clear beats step; units roll 9->0 into tens
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            units_q <= '0;
            tens_q  <= '0;
        end else if (i_Clear) begin
            units_q <= '0;
            tens_q  <= '0;
        end else if (i_Step) begin
            if (o_At_Max) begin
                units_q <= '0;
                tens_q  <= '0;
            end else if (units_q == UNITS_NINE) begin
                units_q <= '0;
                tens_q  <= tens_q + 1'b1;
            end else begin
                units_q <= units_q + 1'b1;
            end
        end
    end

    assign o_Units = units_q;
    assign o_Tens  = tens_q;

endmodule

// File: rtl/clock_counters.sv
// Time-of-day core: seconds, minutes and hours in BCD, 00:00:00..23:59:59.
// Normal mode ripples carries through the fields in a single edge, each
// carry gated by the next field's enable. Set mode steps minutes or hours
// directly, minutes having priority, with no carry between fields.
module clock_counters
    import clock_pkg::*;
(
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic                   i_Reset_Sec,
    input  logic                   i_Enable_Increment,
    input  logic                   i_Enable_Count_Sec,
    input  logic                   i_Enable_Count_Min,
    input  logic                   i_Enable_Count_Hour,
    output logic [UNITS_W-1:0]     o_Units_Sec,
    output logic [SEC_TENS_W-1:0]  o_Tens_Sec,
    output logic [UNITS_W-1:0]     o_Units_Min,
    output logic [MIN_TENS_W-1:0]  o_Tens_Min,
    output logic [UNITS_W-1:0]     o_Units_Hour,
    output logic [HOUR_TENS_W-1:0] o_Tens_Hour
);

    logic sec_at_max, min_at_max, hour_at_max;
    logic sec_step, sec_carry;
    logic min_step, min_carry;
    logic hour_step;

    // Step/carry gating; a seconds clear suppresses both the tick and its carry
    always_comb begin
        sec_step  = ~i_Enable_Increment & i_Enable_Count_Sec & ~i_Reset_Sec;
        sec_carry = sec_step & sec_at_max;
        if (i_Enable_Increment) begin
            min_step  = i_Enable_Count_Min;
            min_carry = 1'b0;
            hour_step = i_Enable_Count_Hour & ~i_Enable_Count_Min;
        end else begin
            min_step  = sec_carry & i_Enable_Count_Min;
            min_carry = min_step & min_at_max;
            hour_step = min_carry & i_Enable_Count_Hour;
        end
    end

    bcd_mod_counter #(
        .TENS_W                (SEC_TENS_W),
        .TENS_MAX              (SEC_TENS_MAX),
        .UNITS_MAX_AT_TENS_MAX (SEC_UNITS_MAX)
    ) u_sec (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (i_Reset_Sec),
        .i_Step    (sec_step),
        .o_Units   (o_Units_Sec),
        .o_Tens    (o_Tens_Sec),
        .o_At_Max  (sec_at_max)
    );

    bcd_mod_counter #(
        .TENS_W                (MIN_TENS_W),
        .TENS_MAX              (MIN_TENS_MAX),
        .UNITS_MAX_AT_TENS_MAX (MIN_UNITS_MAX)
    ) u_min (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (1'b0),
        .i_Step    (min_step),
        .o_Units   (o_Units_Min),
        .o_Tens    (o_Tens_Min),
        .o_At_Max  (min_at_max)
    );

    bcd_mod_counter #(
        .TENS_W                (HOUR_TENS_W),
        .TENS_MAX              (HOUR_TENS_MAX),
        .UNITS_MAX_AT_TENS_MAX (HOUR_UNITS_MAX)
    ) u_hour (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (1'b0),
        .i_Step    (hour_step),
        .o_Units   (o_Units_Hour),
        .o_Tens    (o_Tens_Hour),
        .o_At_Max  (hour_at_max)
    );

    // Hours terminal flag is not needed: nothing sits above the hours field
    logic unused_hour_at_max;
    assign unused_hour_at_max = hour_at_max;

endmodule

// File: tb/tb_clock_counters.sv
// Directed bench for clock_counters. Inputs change on the falling edge and
// outputs are compared on the falling edge, half a period after the edge
// that updated them. Expected times are written as plain h/m/s constants.
module tb_clock_counters;

    logic       i_Clock;
    logic       i_Reset_n;
    logic       i_Reset_Sec;
    logic       i_Enable_Increment;
    logic       i_Enable_Count_Sec;
    logic       i_Enable_Count_Min;
    logic       i_Enable_Count_Hour;
    logic [3:0] o_Units_Sec;
    logic [2:0] o_Tens_Sec;
    logic [3:0] o_Units_Min;
    logic [2:0] o_Tens_Min;
    logic [3:0] o_Units_Hour;
    logic [1:0] o_Tens_Hour;

    int checks   = 0;
    int failures = 0;

    clock_counters dut (
        .i_Clock             (i_Clock),
        .i_Reset_n           (i_Reset_n),
        .i_Reset_Sec         (i_Reset_Sec),
        .i_Enable_Increment  (i_Enable_Increment),
        .i_Enable_Count_Sec  (i_Enable_Count_Sec),
        .i_Enable_Count_Min  (i_Enable_Count_Min),
        .i_Enable_Count_Hour (i_Enable_Count_Hour),
        .o_Units_Sec         (o_Units_Sec),
        .o_Tens_Sec          (o_Tens_Sec),
        .o_Units_Min         (o_Units_Min),
        .o_Tens_Min          (o_Tens_Min),
        .o_Units_Hour        (o_Units_Hour),
        .o_Tens_Hour         (o_Tens_Hour)
    );

    // Clock / reset
    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    // Driver: set all control inputs (applied on a falling edge)
    task automatic drive(input logic inc, input logic sec, input logic min,
                         input logic hour, input logic rsec);
        i_Enable_Increment  = inc;
        i_Enable_Count_Sec  = sec;
        i_Enable_Count_Min  = min;
        i_Enable_Count_Hour = hour;
        i_Reset_Sec         = rsec;
    endtask

    // Driver: let n rising edges pass, return on the following falling edge
    task automatic run(input int n);
        repeat (n) @(posedge i_Clock);
        @(negedge i_Clock);
    endtask

    // Scoreboard: compare all six digits against hh:mm:ss
    task automatic check_time(input string tag, input int h, input int m, input int s);
        logic [3:0] eus, eum, euh;
        logic [2:0] ets, etm;
        logic [1:0] eth;
        eus = 4'(s % 10); ets = 3'(s / 10);
        eum = 4'(m % 10); etm = 3'(m / 10);
        euh = 4'(h % 10); eth = 2'(h / 10);
        checks++;
        assert (o_Units_Sec === eus) else begin
            failures++;
            $error("FAIL %s units_sec got=%0d exp=%0d", tag, o_Units_Sec, eus);
        end
        checks++;
        assert (o_Tens_Sec === ets) else begin
            failures++;
            $error("FAIL %s tens_sec got=%0d exp=%0d", tag, o_Tens_Sec, ets);
        end
        checks++;
        assert (o_Units_Min === eum) else begin
            failures++;
            $error("FAIL %s units_min got=%0d exp=%0d", tag, o_Units_Min, eum);
        end
        checks++;
        assert (o_Tens_Min === etm) else begin
            failures++;
            $error("FAIL %s tens_min got=%0d exp=%0d", tag, o_Tens_Min, etm);
        end
        checks++;
        assert (o_Units_Hour === euh) else begin
            failures++;
            $error("FAIL %s units_hour got=%0d exp=%0d", tag, o_Units_Hour, euh);
        end
        checks++;
        assert (o_Tens_Hour === eth) else begin
            failures++;
            $error("FAIL %s tens_hour got=%0d exp=%0d", tag, o_Tens_Hour, eth);
        end
    endtask

    // Directed sequence
    initial begin
        i_Reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(posedge i_Clock);
        @(negedge i_Clock);
        check_time("reset_held", 0, 0, 0);
        i_Reset_n = 1'b1;

        // Seconds only, carry into minutes disabled
        drive(0, 1, 0, 0, 0);
        run(59);  check_time("sec_only_59", 0, 0, 59);
        run(1);   check_time("sec_wrap_no_carry", 0, 0, 0);

        // Normal mode, full cascade enabled
        drive(0, 1, 1, 1, 0);
        run(60);    check_time("norm_60", 0, 1, 0);
        run(3540);  check_time("norm_3600", 1, 0, 0);
        run(41696); check_time("norm_12_34_56", 12, 34, 56);

        // Idle hold, then 4 ticks with minutes carry enabled
        drive(0, 0, 0, 0, 0);
        run(100); check_time("idle_100", 12, 34, 56);
        drive(0, 1, 1, 0, 0);
        run(4);   check_time("carry_min_on", 12, 35, 0);

        // Same boundary with minutes carry disabled
        drive(0, 1, 0, 0, 0);
        run(56);  check_time("sec_to_56", 12, 35, 56);
        run(4);   check_time("carry_min_off", 12, 35, 0);

        // Asynchronous reset between edges
        drive(0, 0, 0, 0, 0);
        #2;
        i_Reset_n = 1'b0;
        #1;
        check_time("async_reset", 0, 0, 0);
        i_Reset_n = 1'b1;
        @(negedge i_Clock);

        // Set mode: minutes win when both enables high; seconds never tick
        drive(1, 1, 1, 1, 0);
        run(2);   check_time("set_both", 0, 2, 0);
        drive(1, 1, 0, 1, 0);
        run(2);   check_time("set_hours", 2, 2, 0);
        drive(1, 0, 1, 0, 0);
        run(57);  check_time("set_min_59", 2, 59, 0);
        run(1);   check_time("set_min_wrap", 2, 0, 0);
        drive(1, 0, 0, 1, 0);
        run(21);  check_time("set_hour_23", 23, 0, 0);
        run(1);   check_time("set_hour_wrap", 0, 0, 0);

        // Seconds clear beats a simultaneous tick
        drive(1, 0, 1, 0, 0);
        run(5);   check_time("set_min_5", 0, 5, 0);
        drive(0, 1, 0, 0, 0);
        run(42);  check_time("sec_to_42", 0, 5, 42);
        drive(0, 1, 1, 1, 1);
        run(1);   check_time("clr_vs_tick", 0, 5, 0);
        drive(0, 1, 1, 1, 0);
        run(59);  check_time("sec_to_59", 0, 5, 59);
        drive(0, 1, 1, 1, 1);
        run(1);   check_time("clr_no_carry", 0, 5, 0);

        // Seconds clear in set mode alongside a minute step
        drive(0, 1, 0, 0, 0);
        run(10);  check_time("sec_to_10", 0, 5, 10);
        drive(1, 0, 1, 0, 1);
        run(1);   check_time("set_clr_min", 0, 6, 0);

        // Reach 23:59:59 and take the full cascade in one edge
        drive(1, 0, 0, 1, 0);
        run(23);  check_time("set_to_23", 23, 6, 0);
        drive(1, 0, 1, 0, 0);
        run(53);  check_time("set_to_59", 23, 59, 0);
        drive(0, 1, 1, 1, 0);
        run(59);  check_time("at_23_59_59", 23, 59, 59);
        run(1);   check_time("full_wrap", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
